lsq_unit: RTL and testbench
===========================

LSQ_UNIT -- requirements
Module: lsq_unit

Interface
REQ-001 Parameter DATA_W, default 8, width of data values and of memory words.
REQ-002 Parameter ADDR_W, default 8, memory address width; memory depth is 2**ADDR_W words.
REQ-003 Parameter TAG_W, default 4, width of result/source tags.
REQ-004 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all queue state.
REQ-007 disp_valid  in  1  dispatch request.
REQ-008 disp_ready  out  1  queue can accept; equals not full.
REQ-009 disp_is_store  in  1  1 = store, 0 = load.
REQ-010 disp_addr  in  ADDR_W  memory address.
REQ-011 disp_tag  in  TAG_W  load: destination tag; store: source-data tag.
REQ-012 disp_virt  in  1  store only: 1 = data pending on disp_tag, 0 = disp_data valid.
REQ-013 disp_data  in  DATA_W  store data when disp_virt=0.
REQ-014 cdb_valid, cdb_tag, cdb_data  in  1/TAG_W/DATA_W  result broadcast from other units.
REQ-015 ld_valid, ld_tag, ld_data  out  1/TAG_W/DATA_W  load result, one-cycle pulse.
REQ-016 count  out  clog2(DEPTH)+1  occupied entries; full, empty  out  1  status flags.

Function
REQ-017 Queue SHALL be a circular buffer (head, tail, count) holding loads and stores in program order; wrap-around at DEPTH.
REQ-018 Entry accepted on a rising edge with disp_valid && disp_ready; dispatch while full SHALL be ignored with no state change.
REQ-019 Each entry holds: valid, is_store, addr, tag, data, data_rdy (stores), issued (loads).
REQ-020 A store with data_rdy=0 SHALL capture cdb_data when cdb_valid && cdb_tag==its tag; this includes the dispatch edge itself (same-cycle CDB match at dispatch sets data_rdy=1).
REQ-021 Load hazard: a load SHALL NOT issue while any older store with equal addr has data_rdy=0.
REQ-022 Load issue: each cycle, the oldest non-issued, hazard-free load SHALL be selected; at most one load issues per cycle.
REQ-023 Forwarding: if older stores match addr, the issued load SHALL return the data of the youngest such store; otherwise it SHALL return memory[addr].
REQ-024 The load result SHALL be registered: a load issued at edge N drives ld_valid=1, ld_tag, ld_data for exactly the cycle after edge N.
REQ-025 A load accepted at edge N into a queue with no hazard SHALL issue at edge N+1 (ld_valid high in the cycle after N+1).
REQ-026 Retire: at most one entry per edge, only from head; a head store retires when data_rdy=1 and SHALL write memory[addr]=data on that edge; a head load retires once issued.
REQ-027 Stores SHALL write memory strictly in program order; WAW to one address leaves the youngest data.
REQ-028 A store issued and retired on the same edge as an issuing load to the same address SHALL NOT disturb forwarding (the load forwards from the store entry).
REQ-029 Simultaneous dispatch and retire on one edge SHALL leave count unchanged; full and empty derive from the registered count.
REQ-030 CDB is snooped only by stores; loads ignore cdb_*.
REQ-031 Memory SHALL be an internal 2**ADDR_W x DATA_W array, not cleared by reset.

Reset
REQ-032 While reset=1: head=tail=count=0, all entry valid=0, ld_valid=0, ld_tag=0, ld_data=0, empty=1, full=0, disp_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all entries, including pending stores, without writing memory; issued-but-unreported loads are dropped.

Verification
REQ-034 Store addr 0x10, data 0x5A, virt=0 into empty queue; then load addr 0x10 tag 3 -> ld_valid with ld_tag=3, ld_data=0x5A; memory[0x10]=0x5A after retire.
REQ-035 Store addr 0x20, virt=1, tag 7; load addr 0x20 tag 2; hold 5 cycles -> no ld_valid; cdb_valid, tag 7, data 0x33 -> next cycle load issues, then ld_data=0x33.
REQ-036 Stores 0x11 then 0x22 to addr 0x30, then load 0x30 -> ld_data=0x22; memory[0x30]=0x22 after both retire.
REQ-037 DEPTH=4: dispatch 4 virt=1 stores -> full=1, disp_ready=0; fifth dispatch ignored; CDB for oldest tag -> one retire, count=3, full=0.
REQ-038 Blocked load at 0x40 behind pending store, younger load at 0x41 (memory 0x99) -> younger load returns 0x99 first.
REQ-039 Assert reset with 3 pending stores -> count=0, empty=1, those memory locations unchanged.

Source files
------------

// File: rtl/lsq_unit.sv
// In-order load/store queue: circular buffer of loads and stores with CDB
// snooping for pending store data, store-to-load forwarding and a private data memory.
module lsq_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic                   disp_is_store,
  input  logic [ADDR_W-1:0]      disp_addr,
  input  logic [TAG_W-1:0]       disp_tag,
  input  logic                   disp_virt,
  input  logic [DATA_W-1:0]      disp_data,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_data,
  output logic                   ld_valid,
  output logic [TAG_W-1:0]       ld_tag,
  output logic [DATA_W-1:0]      ld_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MEM_D = 2 ** ADDR_W;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, is_store_q, is_store_d;
  logic [DEPTH-1:0]  rdy_q, rdy_d, issued_q, issued_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              ld_valid_q, ld_valid_d;
  logic [TAG_W-1:0]  ld_tag_q, ld_tag_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic [DATA_W-1:0] mem_q [MEM_D];

  logic              accept, retire, mem_we, disp_cdb_hit;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [PTR_W-1:0]  idx, jdx, sel_idx;
  logic              haz, hit, match, cand, sel_found, sel_hit;
  logic [DATA_W-1:0] fdata, sel_fdata;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == CNT_W'(0));
  assign disp_ready = ~full;
  assign accept     = disp_valid & disp_ready;
  assign count      = count_q;
  assign ld_valid   = ld_valid_q;
  assign ld_tag     = ld_tag_q;
  assign ld_data    = ld_data_q;

  // Next-state: CDB snoop, load selection/forwarding, head retire, tail dispatch
  always_comb begin
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    valid_d = valid_q;  is_store_d = is_store_q;  rdy_d = rdy_q;  issued_d = issued_q;
    addr_d = addr_q;  tag_d = tag_q;  data_d = data_q;
    ld_valid_d = 1'b0;  ld_tag_d = '0;  ld_data_d = '0;
    retire = 1'b0;  mem_we = 1'b0;
    mem_waddr = addr_q[head_q];  mem_wdata = data_q[head_q];
    idx = '0;  jdx = '0;  haz = 1'b0;  hit = 1'b0;  match = 1'b0;  cand = 1'b0;
    fdata = '0;  sel_found = 1'b0;  sel_idx = '0;  sel_hit = 1'b0;  sel_fdata = '0;
    disp_cdb_hit = cdb_valid & (cdb_tag == disp_tag);

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && is_store_q[i] && !rdy_q[i] && cdb_valid && (cdb_tag == tag_q[i])) begin
        rdy_d[i]  = 1'b1;
        data_d[i] = cdb_data;
      end else begin
        rdy_d[i]  = rdy_q[i];
      end
    end

    // Walk entries oldest first; the youngest older matching store wins forwarding
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      haz = 1'b0;  hit = 1'b0;  fdata = '0;
      for (int j = 0; j < DEPTH; j++) begin
        jdx   = head_q + PTR_W'(j);
        match = (j < k) && valid_q[jdx] && is_store_q[jdx] && (addr_q[jdx] == addr_q[idx]);
        hit   = hit | match;
        haz   = haz | (match & ~rdy_q[jdx]);
        fdata = match ? data_q[jdx] : fdata;
      end
      cand = !sel_found && valid_q[idx] && !is_store_q[idx] && !issued_q[idx] && !haz;
      if (cand) begin
        sel_found = 1'b1;  sel_idx = idx;  sel_hit = hit;  sel_fdata = fdata;
      end else begin
        sel_found = sel_found;
      end
    end

    if (sel_found) begin
      issued_d[sel_idx] = 1'b1;
      ld_valid_d = 1'b1;
      ld_tag_d   = tag_q[sel_idx];
      ld_data_d  = sel_hit ? sel_fdata : mem_q[addr_q[sel_idx]];
    end else begin
      ld_valid_d = 1'b0;
    end

    if (valid_q[head_q] && (is_store_q[head_q] ? rdy_q[head_q] : issued_q[head_q])) begin
      retire          = 1'b1;
      mem_we          = is_store_q[head_q];
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end else begin
      retire = 1'b0;
    end

    if (accept) begin
      valid_d[tail_q]    = 1'b1;
      is_store_d[tail_q] = disp_is_store;
      addr_d[tail_q]     = disp_addr;
      tag_d[tail_q]      = disp_tag;
      issued_d[tail_q]   = 1'b0;
      if (disp_is_store && disp_virt) begin
        rdy_d[tail_q]  = disp_cdb_hit;
        data_d[tail_q] = disp_cdb_hit ? cdb_data : '0;
      end else if (disp_is_store) begin
        rdy_d[tail_q]  = 1'b1;
        data_d[tail_q] = disp_data;
      end else begin
        rdy_d[tail_q]  = 1'b0;
        data_d[tail_q] = '0;
      end
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end

    case ({accept, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state and registered load result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      is_store_q <= '0;
      rdy_q      <= '0;
      issued_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      ld_valid_q <= 1'b0;
      ld_tag_q   <= '0;
      ld_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      is_store_q <= is_store_d;
      rdy_q      <= rdy_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      ld_valid_q <= ld_valid_d;
      ld_tag_q   <= ld_tag_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // Data memory survives reset; only retiring stores write it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_lsq_unit.sv
// Bench for lsq_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lsq_unit;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       disp_valid = 1'b0, disp_is_store = 1'b0, disp_virt = 1'b0;
  logic [7:0] disp_addr = 8'h00, disp_data = 8'h00;
  logic [3:0] disp_tag = 4'h0;
  logic       cdb_valid = 1'b0;
  logic [3:0] cdb_tag = 4'h0;
  logic [7:0] cdb_data = 8'h00;
  logic       disp_ready, ld_valid, full, empty;
  logic [3:0] ld_tag;
  logic [7:0] ld_data;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  lsq_unit #(.DATA_W(8), .ADDR_W(8), .TAG_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_store(disp_is_store),
    .disp_addr(disp_addr), .disp_tag(disp_tag), .disp_virt(disp_virt), .disp_data(disp_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: program-ordered list of entries plus a memory image
  typedef struct {
    bit st; logic [7:0] a; logic [3:0] t; logic [7:0] d; bit rdy; bit iss;
  } ent_t;
  ent_t       mq[$];
  logic [7:0] mmem [256];
  bit         mknown [256];
  bit         e_valid = 1'b0, e_known = 1'b1;
  logic [3:0] e_tag = 4'h0;
  logic [7:0] e_data = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      e_valid = 1'b0; e_tag = 4'h0; e_data = 8'h00; e_known = 1'b1;
    end else begin
      int n; bit acc, ret, found, blk, hit; logic [7:0] fd; ent_t ne;
      n   = mq.size();
      acc = disp_valid && (n < DEPTH);
      ret = (n > 0) && (mq[0].st ? mq[0].rdy : mq[0].iss);
      found = 1'b0; e_valid = 1'b0; e_tag = 4'h0; e_data = 8'h00; e_known = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (!found && !mq[i].st && !mq[i].iss) begin
          blk = 1'b0; hit = 1'b0; fd = 8'h00;
          for (int j = 0; j < i; j++) begin
            if (mq[j].st && mq[j].a == mq[i].a) begin
              hit = 1'b1; fd = mq[j].d;
              if (!mq[j].rdy) blk = 1'b1;
            end
          end
          if (!blk) begin
            found = 1'b1; mq[i].iss = 1'b1; e_valid = 1'b1; e_tag = mq[i].t;
            if (hit) e_data = fd;
            else begin e_data = mmem[mq[i].a]; e_known = mknown[mq[i].a]; end
          end
        end
      end
      for (int i = 0; i < n; i++) begin
        if (mq[i].st && !mq[i].rdy && cdb_valid && cdb_tag == mq[i].t) begin
          mq[i].rdy = 1'b1; mq[i].d = cdb_data;
        end
      end
      if (ret) begin
        if (mq[0].st) begin mmem[mq[0].a] = mq[0].d; mknown[mq[0].a] = 1'b1; end
        void'(mq.pop_front());
      end
      if (acc) begin
        ne.st = disp_is_store; ne.a = disp_addr; ne.t = disp_tag; ne.iss = 1'b0;
        if (!disp_is_store) begin ne.rdy = 1'b0; ne.d = 8'h00; end
        else if (!disp_virt) begin ne.rdy = 1'b1; ne.d = disp_data; end
        else if (cdb_valid && cdb_tag == disp_tag) begin ne.rdy = 1'b1; ne.d = cdb_data; end
        else begin ne.rdy = 1'b0; ne.d = 8'h00; end
        mq.push_back(ne);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_ld_valid", ld_valid, e_valid);
    if (e_valid) begin
      chk("m_ld_tag", ld_tag, e_tag);
      if (e_known) chk("m_ld_data", ld_data, e_data);
    end
    chk("m_count", count, mq.size());
    chk("m_full", full, mq.size() == DEPTH);
    chk("m_empty", empty, mq.size() == 0);
    chk("m_disp_ready", disp_ready, mq.size() != DEPTH);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic disp(input bit st, input logic [7:0] a, input logic [3:0] t,
                      input bit v, input logic [7:0] d);
    disp_valid = 1'b1; disp_is_store = st; disp_addr = a; disp_tag = t;
    disp_virt = v; disp_data = d;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [7:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_ld(input string nm, input logic [3:0] t, input logic [7:0] d);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (ld_valid) begin
        got = 1'b1;
        chk({nm, "_tag"}, ld_tag, t);
        chk({nm, "_data"}, ld_data, d);
      end
      tick();
    end
    chk({nm, "_seen"}, got, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ready", disp_ready, 1'b1);
    chk("rst_ld_valid", ld_valid, 1'b0);
    chk("rst_ld_tag", ld_tag, 4'h0);
    chk("rst_ld_data", ld_data, 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // Store then load to the same address; load latency of two edges
    disp(1'b1, 8'h10, 4'h0, 1'b0, 8'h5A);
    disp(1'b0, 8'h10, 4'h3, 1'b0, 8'h00);
    @(negedge clk);
    chk("s1_lat_early", ld_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("s1_lat_valid", ld_valid, 1'b1);
    chk("s1_tag", ld_tag, 4'h3);
    chk("s1_data", ld_data, 8'h5A);
    tick();
    tick();
    disp(1'b0, 8'h10, 4'h4, 1'b0, 8'h00);
    wait_ld("s1_mem", 4'h4, 8'h5A);

    // Load blocked behind a store waiting on the CDB
    disp(1'b1, 8'h20, 4'h7, 1'b1, 8'h00);
    disp(1'b0, 8'h20, 4'h2, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s2_blocked", ld_valid, 1'b0);
      tick();
    end
    cdb(4'h7, 8'h33);
    wait_ld("s2", 4'h2, 8'h33);

    // WAW to one address: youngest store data wins
    disp(1'b1, 8'h30, 4'h0, 1'b0, 8'h11);
    disp(1'b1, 8'h30, 4'h0, 1'b0, 8'h22);
    disp(1'b0, 8'h30, 4'h5, 1'b0, 8'h00);
    wait_ld("s3", 4'h5, 8'h22);
    tick(); tick();
    disp(1'b0, 8'h30, 4'h6, 1'b0, 8'h00);
    wait_ld("s3_mem", 4'h6, 8'h22);

    // Fill the queue, ignore a dispatch while full, drain one entry
    for (int i = 0; i < 4; i++) disp(1'b1, 8'h50 + 8'(i), 4'(8 + i), 1'b1, 8'h00);
    @(negedge clk);
    chk("s4_full", full, 1'b1);
    chk("s4_ready", disp_ready, 1'b0);
    chk("s4_count", count, 3'd4);
    disp(1'b1, 8'h54, 4'h0, 1'b0, 8'hEE);
    @(negedge clk);
    chk("s4_ignored_count", count, 3'd4);
    cdb(4'h8, 8'hA1);
    tick();
    @(negedge clk);
    chk("s4_after_count", count, 3'd3);
    chk("s4_after_full", full, 1'b0);
    cdb(4'h9, 8'hA2);
    cdb(4'hA, 8'hA3);
    cdb(4'hB, 8'hA4);
    tick(); tick(); tick();

    // Younger hazard-free load overtakes a blocked older load
    disp(1'b1, 8'h41, 4'h0, 1'b0, 8'h99);
    tick(); tick();
    disp(1'b1, 8'h40, 4'hC, 1'b1, 8'h00);
    disp(1'b0, 8'h40, 4'h1, 1'b0, 8'h00);
    disp(1'b0, 8'h41, 4'h6, 1'b0, 8'h00);
    wait_ld("s5_young", 4'h6, 8'h99);
    cdb(4'hC, 8'h77);
    wait_ld("s5_old", 4'h1, 8'h77);

    // CDB match on the dispatch edge itself
    cdb_valid = 1'b1; cdb_tag = 4'h9; cdb_data = 8'h44;
    disp(1'b1, 8'h70, 4'h9, 1'b1, 8'h00);
    cdb_valid = 1'b0;
    disp(1'b0, 8'h70, 4'hA, 1'b0, 8'h00);
    wait_ld("s6", 4'hA, 8'h44);

    // Reset with pending stores must not write memory
    disp(1'b1, 8'h60, 4'h0, 1'b0, 8'h01);
    disp(1'b1, 8'h61, 4'h0, 1'b0, 8'h02);
    disp(1'b1, 8'h62, 4'h0, 1'b0, 8'h03);
    tick(); tick(); tick();
    disp(1'b1, 8'h60, 4'hD, 1'b1, 8'hF0);
    disp(1'b1, 8'h61, 4'hE, 1'b1, 8'hF1);
    disp(1'b1, 8'h62, 4'hF, 1'b1, 8'hF2);
    @(negedge clk);
    chk("s7_pending", count, 3'd3);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("s7_rst_count", count, 3'd0);
    chk("s7_rst_empty", empty, 1'b1);
    tick();
    reset = 1'b0;
    cdb(4'hD, 8'hBB);
    disp(1'b0, 8'h60, 4'h1, 1'b0, 8'h00);
    wait_ld("s7_m60", 4'h1, 8'h01);
    disp(1'b0, 8'h61, 4'h2, 1'b0, 8'h00);
    wait_ld("s7_m61", 4'h2, 8'h02);
    disp(1'b0, 8'h62, 4'h3, 1'b0, 8'h00);
    wait_ld("s7_m62", 4'h3, 8'h03);

    tick(); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
